// File: rtl/spi_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl_if
//   Bus between the SPI command sequencer and the ASCON core.
//   master : sequencer side (drives key/nonce/din/decrypt/core_start)
//   slave  : core side (drives core_done/core_dout/core_tag/core_auth_fail)
//   key, nonce     KEY_W   operand registers
//   din            DATA_W  data block to process
//   decrypt        1       0 = encrypt, 1 = decrypt
//   core_start     1       one-cycle start pulse
//   core_done      1       one-cycle completion pulse
//   core_dout      DATA_W  result block, valid with core_done
//   core_tag       KEY_W   result tag, valid with core_done
//   core_auth_fail 1       tag mismatch on decrypt, valid with core_done
// -----------------------------------------------------------------------------
interface spi_cmd_ctrl_if #(
    parameter int KEY_W  = 128,
    parameter int DATA_W = 64
);
    logic [KEY_W-1:0]  key;
    logic [KEY_W-1:0]  nonce;
    logic [DATA_W-1:0] din;
    logic              decrypt;
    logic              core_start;
    logic              core_done;
    logic [DATA_W-1:0] core_dout;
    logic [KEY_W-1:0]  core_tag;
    logic              core_auth_fail;

    modport master (
        output key, nonce, din, decrypt, core_start,
        input  core_done, core_dout, core_tag, core_auth_fail
    );

    modport slave (
        input  key, nonce, din, decrypt, core_start,
        output core_done, core_dout, core_tag, core_auth_fail
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl
//   SPI command sequencer in front of the ASCON core. Opcode frames are
//   shifted in on sdi (MSB first) while cs_n is low; writes land in the
//   key/nonce/din registers, START opcodes kick the core, and reads shift
//   the captured result or status out on sdo (MSB first, registered).
// Ports
//   interface_clk  in   sole clock, doubles as the SPI serial clock
//   reset_n        in   asynchronous active-low reset
//   cs_n           in   frame select, active low
//   sdi            in   serial in, sampled on rising edge
//   sdo            out  serial out, registered
//   core           bus  master side of spi_cmd_ctrl_if (core operands/results)
//   valid          out  result held and readable
//   auth_fail      out  captured auth fail qualified by valid
//   trigger        out  high while the core is busy
// -----------------------------------------------------------------------------
module spi_cmd_ctrl #(
    parameter int KEY_W  = 128,
    parameter int DATA_W = 64,
    parameter int OP_W   = 8
) (
    input  logic               interface_clk,
    input  logic               reset_n,
    input  logic               cs_n,
    input  logic               sdi,
    output logic               sdo,
    spi_cmd_ctrl_if.master     core,
    output logic               valid,
    output logic               auth_fail,
    output logic               trigger
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    localparam logic [OP_W-1:0] OP_WR_KEY    = OP_W'(8'h01);
    localparam logic [OP_W-1:0] OP_WR_NONCE  = OP_W'(8'h02);
    localparam logic [OP_W-1:0] OP_WR_DATA   = OP_W'(8'h03);
    localparam logic [OP_W-1:0] OP_START_ENC = OP_W'(8'h04);
    localparam logic [OP_W-1:0] OP_START_DEC = OP_W'(8'h05);
    localparam logic [OP_W-1:0] OP_RD_DATA   = OP_W'(8'h06);
    localparam logic [OP_W-1:0] OP_RD_TAG    = OP_W'(8'h07);
    localparam logic [OP_W-1:0] OP_RD_STATUS = OP_W'(8'h08);

    typedef enum logic [2:0] {S_IDLE, S_OPC, S_WR, S_RD, S_IGN} state_t;
    typedef enum logic [1:0] {T_KEY, T_NONCE, T_DATA} tgt_t;

    state_t            state;
    tgt_t              wr_tgt;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-2:0]   op_sr;
    logic [KEY_W-2:0]  shadow;
    logic [KEY_W-1:0]  out_sr;
    logic              busy;
    logic              err;
    logic              auth_q;
    logic [DATA_W-1:0] dout_q;
    logic [KEY_W-1:0]  tag_q;

    logic [OP_W-1:0]   op_now;
    logic [CNT_W-1:0]  wr_last;
    logic [7:0]        status;

    // Opcode including the bit being sampled on this edge.
    assign op_now  = {op_sr, sdi};
    assign wr_last = (wr_tgt == T_DATA) ? CNT_W'(DATA_W - 1) : CNT_W'(KEY_W - 1);

    assign trigger   = busy;
    assign auth_fail = auth_q & valid;
    assign status    = {4'b0000, err, auth_fail, valid, busy};

    // Reads are left-aligned in out_sr and shifted with zero fill, so sdo
    // falls to 0 by itself once the last bit has gone out.
    assign sdo = out_sr[KEY_W-1];

    always_ff @(posedge interface_clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            wr_tgt          <= T_KEY;
            cnt             <= '0;
            op_sr           <= '0;
            shadow          <= '0;
            out_sr          <= '0;
            busy            <= 1'b0;
            err             <= 1'b0;
            auth_q          <= 1'b0;
            valid           <= 1'b0;
            dout_q          <= '0;
            tag_q           <= '0;
            core.key        <= '0;
            core.nonce      <= '0;
            core.din        <= '0;
            core.decrypt    <= 1'b0;
            core.core_start <= 1'b0;
        end else begin
            core.core_start <= 1'b0;

            // Completion. Decode below reads the pre-capture register values,
            // so a START on this edge still sees busy and a status read
            // reports the old state. busy gates both sides exclusively.
            if (busy && core.core_done) begin
                busy   <= 1'b0;
                valid  <= 1'b1;
                dout_q <= core.core_dout;
                tag_q  <= core.core_tag;
                auth_q <= core.core_auth_fail;
            end

            if (cs_n) begin
                // Frame abort/end from any state; uncommitted writes are lost.
                state  <= S_IDLE;
                cnt    <= '0;
                out_sr <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // First edge with cs_n low samples opcode bit 1 of OP_W.
                        op_sr <= (OP_W-1)'(sdi);
                        cnt   <= CNT_W'(1);
                        state <= S_OPC;
                    end

                    S_OPC: begin
                        op_sr <= op_now[OP_W-2:0];
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(OP_W - 1)) begin
                            cnt <= '0;
                            case (op_now)
                                OP_WR_KEY: begin
                                    state  <= S_WR;
                                    wr_tgt <= T_KEY;
                                end
                                OP_WR_NONCE: begin
                                    state  <= S_WR;
                                    wr_tgt <= T_NONCE;
                                end
                                OP_WR_DATA: begin
                                    state  <= S_WR;
                                    wr_tgt <= T_DATA;
                                end
                                OP_START_ENC, OP_START_DEC: begin
                                    state <= S_IGN;
                                    if (busy) begin
                                        err <= 1'b1;
                                    end else begin
                                        core.decrypt    <= op_now[0];
                                        core.core_start <= 1'b1;
                                        busy            <= 1'b1;
                                        valid           <= 1'b0;
                                    end
                                end
                                OP_RD_DATA: begin
                                    state  <= S_RD;
                                    out_sr <= KEY_W'(dout_q) << (KEY_W - DATA_W);
                                end
                                OP_RD_TAG: begin
                                    state  <= S_RD;
                                    out_sr <= tag_q;
                                end
                                OP_RD_STATUS: begin
                                    // Shift out the value before the clear.
                                    state  <= S_RD;
                                    out_sr <= KEY_W'(status) << (KEY_W - 8);
                                    err    <= 1'b0;
                                end
                                default: begin
                                    state <= S_IGN;
                                    err   <= 1'b1;
                                end
                            endcase
                        end
                    end

                    S_WR: begin
                        shadow <= {shadow[KEY_W-3:0], sdi};
                        cnt    <= cnt + 1'b1;
                        if (cnt == wr_last) begin
                            // Commit edge; anything after it is sunk.
                            state <= S_IGN;
                            if (busy) begin
                                err <= 1'b1;
                            end else begin
                                case (wr_tgt)
                                    T_KEY:   core.key   <= {shadow, sdi};
                                    T_NONCE: core.nonce <= {shadow, sdi};
                                    default: core.din   <= {shadow[DATA_W-2:0], sdi};
                                endcase
                            end
                        end
                    end

                    S_RD: begin
                        out_sr <= out_sr << 1;
                    end

                    default: begin
                        // S_IGN: sink bits until cs_n rises.
                        out_sr <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_ctrl
//   Directed bench for spi_cmd_ctrl. Inputs change 1 time unit after each
//   rising edge and outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_spi_cmd_ctrl;

    logic interface_clk = 1'b0;
    logic reset_n;
    logic cs_n;
    logic sdi;
    logic sdo;
    logic valid;
    logic auth_fail;
    logic trigger;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    spi_cmd_ctrl_if #(.KEY_W(128), .DATA_W(64)) cif ();

    spi_cmd_ctrl #(.KEY_W(128), .DATA_W(64), .OP_W(8)) dut (
        .interface_clk (interface_clk),
        .reset_n       (reset_n),
        .cs_n          (cs_n),
        .sdi           (sdi),
        .sdo           (sdo),
        .core          (cif.master),
        .valid         (valid),
        .auth_fail     (auth_fail),
        .trigger       (trigger)
    );

    always #5 interface_clk = ~interface_clk;

    // Count start pulses; a one-cycle pulse is seen at exactly one falling edge.
    always @(negedge interface_clk) if (cif.core_start === 1'b1) start_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge interface_clk);
        #1;
    endtask

    task automatic send_bits(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = v[i];
            tick();
        end
    endtask

    task automatic send_op(input logic [7:0] op);
        cs_n = 1'b0;
        send_bits({120'd0, op}, 8);
    endtask

    // Opcode whose decode edge coincides with a core_done pulse.
    task automatic send_op_done(input logic [7:0] op, input logic [63:0] dout);
        cs_n = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            sdi = op[i];
            tick();
        end
        sdi = op[0];
        cif.core_dout = dout;
        cif.core_done = 1'b1;
        tick();
        cif.core_done = 1'b0;
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        sdi  = 1'b0;
        tick();
        tick();
    endtask

    // Called right after a read decode edge: collects n bits and the bit after.
    task automatic read_bits(input int n, output logic [127:0] val, output logic tail);
        val = '0;
        val[n-1] = sdo;
        for (int i = n - 2; i >= 0; i--) begin
            sdi = 1'b0;
            tick();
            val[i] = sdo;
        end
        tick();
        tail = sdo;
    endtask

    task automatic complete(input logic [63:0] dout, input logic [127:0] tag, input logic af);
        cif.core_dout      = dout;
        cif.core_tag       = tag;
        cif.core_auth_fail = af;
        cif.core_done      = 1'b1;
        tick();
        cif.core_done      = 1'b0;
    endtask

    task automatic test_reset();
        logic [127:0] v;
        logic t;
        reset_n = 1'b0;
        cs_n = 1'b1;
        sdi = 1'b0;
        cif.core_done = 1'b0;
        cif.core_dout = '0;
        cif.core_tag = '0;
        cif.core_auth_fail = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({sdo, valid, auth_fail, trigger, cif.core_start, cif.decrypt} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {sdo, valid, auth_fail, trigger, cif.core_start, cif.decrypt});
        end
        n_checks++;
        if ({cif.key, cif.nonce, cif.din} !== 320'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got key=%h nonce=%h din=%h expected 0", cif.key, cif.nonce, cif.din);
        end
        reset_n = 1'b1;
        tick();
        send_op(8'h08);
        read_bits(8, v, t);
        end_frame();
        n_checks++;
        if (v[7:0] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected 00", v[7:0]);
        end
    endtask

    task automatic test_wr_key();
        logic [127:0] k;
        logic [127:0] v;
        logic t;
        k = 128'h000102030405060708090A0B0C0D0E0F;
        send_op(8'h01);
        send_bits(k >> 1, 127);
        n_checks++;
        if (cif.key !== 128'd0) begin
            n_fail++;
            $display("FAIL key_before_commit: got %h expected 0", cif.key);
        end
        send_bits({127'd0, k[0]}, 1);
        n_checks++;
        if (cif.key !== k) begin
            n_fail++;
            $display("FAIL wr_key: got %h expected %h", cif.key, k);
        end
        end_frame();
        send_op(8'h08);
        read_bits(8, v, t);
        end_frame();
        n_checks++;
        if (v[7:0] !== 8'h00) begin
            n_fail++;
            $display("FAIL wr_key_status: got %h expected 00", v[7:0]);
        end
    endtask

    task automatic test_wr_abort();
        logic [127:0] n;
        n = 128'hA5A5_5A5A_0123_4567_89AB_CDEF_FEDC_BA98;
        send_op(8'h03);
        send_bits({64'd0, 64'h1122334455667788}, 64);
        end_frame();
        n_checks++;
        if (cif.din !== 64'h1122334455667788) begin
            n_fail++;
            $display("FAIL wr_data: got %h expected 1122334455667788", cif.din);
        end
        send_op(8'h03);
        send_bits({88'd0, 40'hFF_FFFF_FFFF}, 40);
        end_frame();
        n_checks++;
        if (cif.din !== 64'h1122334455667788) begin
            n_fail++;
            $display("FAIL wr_abort: got %h expected 1122334455667788", cif.din);
        end
        send_op(8'h02);
        send_bits(n, 128);
        send_bits(128'hFF, 8);
        end_frame();
        n_checks++;
        if (cif.nonce !== n) begin
            n_fail++;
            $display("FAIL wr_nonce_after_abort: got %h expected %h", cif.nonce, n);
        end
    endtask

    task automatic test_exec_enc();
        int s0;
        logic [127:0] v;
        logic [127:0] tag;
        logic t;
        tag = 128'h0F0E0D0C0B0A09080706050403020100;
        s0 = start_cnt;
        send_op(8'h04);
        n_checks++;
        if ({cif.core_start, trigger, cif.decrypt, valid} !== 4'b1100) begin
            n_fail++;
            $display("FAIL start_enc_edge: got start,trig,dec,valid=%b expected 1100",
                     {cif.core_start, trigger, cif.decrypt, valid});
        end
        tick();
        n_checks++;
        if (cif.core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL start_pulse_width: got %b expected 0", cif.core_start);
        end
        end_frame();
        n_checks++;
        if (start_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL start_enc_count: got %0d expected 1", start_cnt - s0);
        end
        complete(64'hDEADBEEF_01234567, tag, 1'b0);
        n_checks++;
        if ({trigger, valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL done_latency: got trig,valid=%b expected 01", {trigger, valid});
        end
        send_op(8'h06);
        read_bits(64, v, t);
        end_frame();
        n_checks++;
        if (v[63:0] !== 64'hDEADBEEF_01234567 || t !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_data: got %h tail %b expected deadbeef01234567 tail 0", v[63:0], t);
        end
        send_op(8'h07);
        read_bits(128, v, t);
        end_frame();
        n_checks++;
        if (v !== tag || t !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_tag: got %h tail %b expected %h tail 0", v, t, tag);
        end
    endtask

    task automatic test_busy_start();
        int s0;
        logic [127:0] v;
        logic t;
        s0 = start_cnt;
        send_op(8'h05);
        end_frame();
        send_op(8'h04);
        end_frame();
        n_checks++;
        if (start_cnt - s0 !== 1 || cif.decrypt !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start: got starts=%0d decrypt=%b expected 1 1", start_cnt - s0, cif.decrypt);
        end
        send_op(8'h08);
        read_bits(8, v, t);
        end_frame();
        n_checks++;
        if (v[7:0] !== 8'h09) begin
            n_fail++;
            $display("FAIL busy_status1: got %h expected 09", v[7:0]);
        end
        send_op(8'h08);
        read_bits(8, v, t);
        end_frame();
        n_checks++;
        if (v[7:0] !== 8'h01) begin
            n_fail++;
            $display("FAIL busy_status2: got %h expected 01", v[7:0]);
        end
    endtask

    task automatic test_auth_fail();
        logic [127:0] v;
        logic t;
        complete(64'h8000_0000_0000_0001, 128'd1, 1'b1);
        n_checks++;
        if ({auth_fail, valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL auth_capture: got auth,valid=%b expected 11", {auth_fail, valid});
        end
        send_op(8'h08);
        read_bits(8, v, t);
        end_frame();
        n_checks++;
        if (v[7:0] !== 8'h06) begin
            n_fail++;
            $display("FAIL auth_status: got %h expected 06", v[7:0]);
        end
        // Stray done while idle must not overwrite the held result.
        complete(64'h0, 128'd0, 1'b0);
        send_op(8'h06);
        read_bits(64, v, t);
        end_frame();
        n_checks++;
        if (v[63:0] !== 64'h8000_0000_0000_0001 || auth_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_done_ignored: got %h auth %b expected 8000000000000001 auth 1",
                     v[63:0], auth_fail);
        end
        send_op(8'h04);
        n_checks++;
        if ({auth_fail, valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_clears_valid: got auth,valid=%b expected 00", {auth_fail, valid});
        end
        end_frame();
    endtask

    task automatic test_back_to_back();
        int s0;
        logic [127:0] v;
        logic t;
        // Core busy from previous START; status decoded on the done edge.
        cif.core_auth_fail = 1'b0;
        send_op_done(8'h08, 64'hCAFEF00D_12345678);
        read_bits(8, v, t);
        end_frame();
        n_checks++;
        if (v[7:0] !== 8'h01 || valid !== 1'b1 || trigger !== 1'b0) begin
            n_fail++;
            $display("FAIL same_edge_status: got %h valid %b trig %b expected 01 1 0", v[7:0], valid, trigger);
        end
        s0 = start_cnt;
        send_op(8'h04);
        end_frame();
        send_op_done(8'h05, 64'hCAFEF00D_12345678);
        end_frame();
        n_checks++;
        if (start_cnt - s0 !== 1 || valid !== 1'b1 || cif.decrypt !== 1'b0) begin
            n_fail++;
            $display("FAIL same_edge_start: got starts=%0d valid=%b dec=%b expected 1 1 0",
                     start_cnt - s0, valid, cif.decrypt);
        end
        send_op(8'h08);
        read_bits(8, v, t);
        end_frame();
        n_checks++;
        if (v[7:0] !== 8'h0A) begin
            n_fail++;
            $display("FAIL same_edge_err: got %h expected 0a", v[7:0]);
        end
    endtask

    task automatic test_ignore_and_reset();
        logic [127:0] v;
        logic t;
        logic bad;
        bad = 1'b0;
        cs_n = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            sdi = v[0];
            sdi = (8'hA5 >> i) & 1'b1;
            tick();
            if (sdo !== 1'b0) bad = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            sdi = 1'b1;
            tick();
            if (sdo !== 1'b0) bad = 1'b1;
        end
        end_frame();
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_sdo: got nonzero sdo expected 0");
        end
        send_op(8'h08);
        read_bits(8, v, t);
        end_frame();
        n_checks++;
        if (v[7:0] !== 8'h0A) begin
            n_fail++;
            $display("FAIL ign_err: got %h expected 0a", v[7:0]);
        end
        send_op(8'h06);
        n_checks++;
        if (sdo !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_msb: got %b expected 1", sdo);
        end
        sdi = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({sdo, valid, auth_fail, trigger, cif.core_start} !== 5'b0 ||
            {cif.key, cif.nonce, cif.din} !== 320'd0) begin
            n_fail++;
            $display("FAIL reset_midread: got sdo,valid,auth,trig,start=%b key=%h din=%h expected all 0",
                     {sdo, valid, auth_fail, trigger, cif.core_start}, cif.key, cif.din);
        end
        cs_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        send_op(8'h08);
        read_bits(8, v, t);
        end_frame();
        n_checks++;
        if (v[7:0] !== 8'h00) begin
            n_fail++;
            $display("FAIL post_reset_status: got %h expected 00", v[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_wr_key();
        test_wr_abort();
        test_exec_enc();
        test_busy_start();
        test_auth_fail();
        test_back_to_back();
        test_ignore_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
